instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage in front of control_unit. Owns the program counter and the instruction register.
//  Issues req/ack reads to instruction memory and presents one instruction to the decoder.
//  Advances on ic_count, redirects on ic_wr_en (branch/jump target), and halts on a timeout
//  or a misaligned target.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded by reset
//  TIMEOUT   16             max cycles imem_req may wait for imem_ack before error (>=2)
//  NOP_INSTR 32'h0000_0013  instr_out value while no valid instruction (addi x0,x0,0)
// PORTS
//  fetch_clk    in   1   clock; all state changes on rising edge
//  fetch_rst_n  in   1   asynchronous, active-low reset
//  ic_count     in   1   decoder done with current instr; PC += 4 and fetch next
//  ic_wr_en     in   1   redirect; PC <= ic_target and fetch there
//  ic_target    in   32  redirect address
//  imem_req     out  1   read request; held high until imem_ack
//  imem_addr    out  32  read address; equals pc_out while imem_req=1
//  imem_ack     in   1   read complete; imem_rdata valid this cycle
//  imem_rdata   in   32  instruction word
//  instr_out    out  32  instruction register to decoder (instr_in of control_unit)
//  instr_valid  out  1   instr_out holds the word fetched from pc_out
//  pc_out       out  32  current PC
//  fetch_err    out  1   sticky error: timeout or misaligned target
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, imem_req=0, instr_out=NOP_INSTR,
//   instr_valid=0, fetch_err=0, kill=0, tmo_cnt=0, state=S_BOOT.
//   Asserting reset mid-transaction drops imem_req at once; the pending ack is not tracked.
//  FSM:
//   S_BOOT: one idle cycle after reset release -> S_REQ.
//   S_REQ: imem_req=1, imem_addr=pc, tmo_cnt increments each cycle without ack.
//    - ack & !kill: instr_out<=imem_rdata, instr_valid<=1, tmo_cnt<=0 -> S_HOLD.
//    - ack & kill: data discarded, kill<=0, tmo_cnt<=0; imem_req=0 for one cycle,
//      then a new request at the (redirected) pc -> S_REQ.
//    - no ack & tmo_cnt==TIMEOUT-1: imem_req<=0, fetch_err<=1 -> S_ERR.
//   S_HOLD: imem_req=0, instr_valid=1; waits for ic_count or ic_wr_en.
//   S_ERR: terminal until reset. imem_req=0, instr_valid=0, instr_out=NOP_INSTR.
//  Redirect (ic_wr_en): pc<=ic_target, instr_valid<=0, instr_out<=NOP_INSTR.
//   - If ic_target[1:0]!=0: fetch_err<=1, no request issued -> S_ERR.
//   - In S_REQ with no ack that cycle: kill<=1; the in-flight request completes, then refetch.
//   - In S_REQ with ack that same cycle: the acked data is dropped;
//     the next cycle requests ic_target.
//   - In S_HOLD: -> S_REQ; imem_req is high the next cycle.
//  Advance (ic_count): honoured only in S_HOLD.
//   pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), instr_valid<=0 -> S_REQ.
//   ic_count outside S_HOLD is ignored.
//  ic_wr_en and ic_count in the same cycle: redirect wins; no +4.
//  Latency: ack in cycle N -> instr_valid=1 in cycle N+1.
//   ic_count in cycle M -> imem_req=1 in cycle M+1. Zero-wait memory (ack same cycle as req)
//   gives one instruction per 2 cycles.
//  imem_addr/imem_req change only on clock edges; no combinational path from inputs to imem_req.
// TESTING
//  1 Reset release, RESET_PC=0, ack after 2 cycles with rdata=32'h00500093
//    -> req in cycle 1, instr_out=32'h00500093, instr_valid=1, pc_out=0.
//  2 Three ic_count pulses with zero-wait memory
//    -> imem_addr sequence 0x4, 0x8, 0xC; instr_valid low 1 cycle between each.
//  3 ic_wr_en=1, target=0x100 asserted mid-wait (ack 3 cycles later)
//    -> stale data discarded, instr_valid stays 0, next req addr=0x100.
//  4 ic_count and ic_wr_en together, target=0x40, pc=0x8
//    -> pc_out=0x40, never 0xC.
//  5 PC at 32'hFFFF_FFFC, ic_count -> imem_addr=0x0.
//    Target 0x102 -> fetch_err=1, imem_req=0, FSM stuck until reset.
//  6 No ack for TIMEOUT cycles -> fetch_err=1 on cycle TIMEOUT, req drops.
//    Reset pulse mid-request -> imem_req=0 and fetch_err=0 immediately (async).

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Fetch stage owning the PC and instruction register; req/ack
//            instruction-memory reads with redirect, kill, timeout and
//            misaligned-target error handling.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        fetch_clk,
    input  logic        fetch_rst_n,
    input  logic        ic_count,
    input  logic        ic_wr_en,
    input  logic [31:0] ic_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic        fetch_err
);

    localparam int C_TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t               r_state;
    logic [31:0]          r_pc;
    logic                 r_req;
    logic [31:0]          r_instr;
    logic                 r_valid;
    logic                 r_err;
    logic                 r_kill;
    logic [C_TMO_W-1:0]   r_tmo_cnt;

    logic                 w_misalign;
    logic                 w_tmo_hit;

    assign w_misalign = (ic_target[1:0] != 2'b00);
    assign w_tmo_hit  = (r_tmo_cnt == C_TMO_W'(TIMEOUT - 1));

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign pc_out      = r_pc;
    assign instr_out   = r_instr;
    assign instr_valid = r_valid;
    assign fetch_err   = r_err;

    always_ff @(posedge fetch_clk or negedge fetch_rst_n) begin
        if (!fetch_rst_n) begin
            r_state   <= S_BOOT;
            r_pc      <= RESET_PC;
            r_req     <= 1'b0;
            r_instr   <= NOP_INSTR;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_kill    <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            case (r_state)
                // Also serves as the one-cycle request gap after a killed fetch
                S_BOOT: begin
                    if (ic_wr_en) begin
                        r_pc <= ic_target;
                    end
                    if (ic_wr_en && w_misalign) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_req     <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (ic_wr_en && w_misalign) begin
                        r_pc    <= ic_target;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_valid <= 1'b0;
                        r_instr <= NOP_INSTR;
                        r_kill  <= 1'b0;
                        r_state <= S_ERR;
                    end else if (ic_wr_en) begin
                        r_pc    <= ic_target;
                        r_valid <= 1'b0;
                        r_instr <= NOP_INSTR;
                        if (imem_ack) begin
                            // Acked word belongs to the old PC; re-request at once
                            r_tmo_cnt <= '0;
                            r_kill    <= 1'b0;
                        end else if (w_tmo_hit) begin
                            r_req   <= 1'b0;
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                            r_kill    <= 1'b1;
                        end
                    end else if (imem_ack) begin
                        r_tmo_cnt <= '0;
                        r_req     <= 1'b0;
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= S_BOOT;
                        end else begin
                            r_instr <= imem_rdata;
                            r_valid <= 1'b1;
                            r_state <= S_HOLD;
                        end
                    end else if (w_tmo_hit) begin
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_valid <= 1'b0;
                        r_instr <= NOP_INSTR;
                        r_state <= S_ERR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (ic_wr_en) begin
                        r_pc    <= ic_target;
                        r_valid <= 1'b0;
                        r_instr <= NOP_INSTR;
                        if (w_misalign) begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end else begin
                            r_req   <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end else if (ic_count) begin
                        r_pc    <= r_pc + 32'd4;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end

                default: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_instr <= NOP_INSTR;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed self-checking bench for instr_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int          C_TIMEOUT = 16;
    localparam logic [31:0] C_NOP     = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        ic_count;
    logic        ic_wr_en;
    logic [31:0] ic_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic        fetch_err;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .TIMEOUT   (C_TIMEOUT),
        .NOP_INSTR (C_NOP)
    ) u_dut (
        .fetch_clk   (clk),
        .fetch_rst_n (rst_n),
        .ic_count    (ic_count),
        .ic_wr_en    (ic_wr_en),
        .ic_target   (ic_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ic_count = 1'b0; ic_wr_en = 1'b0; ic_target = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        step(); step();

        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_instr", instr_out,            C_NOP);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc",    pc_out,               32'h0);
        chk("rst_err",   {31'd0, fetch_err},   32'd0);

        // 1: boot fetch, ack two cycles after the request appears
        rst_n = 1'b1;
        step();
        chk("t1_req_c1",  {31'd0, imem_req}, 32'd1);
        chk("t1_addr_c1", imem_addr,         32'h0);
        step();
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        step();
        imem_ack = 1'b0;
        chk("t1_instr", instr_out,            32'h0050_0093);
        chk("t1_valid", {31'd0, instr_valid}, 32'd1);
        chk("t1_pc",    pc_out,               32'h0);
        chk("t1_req",   {31'd0, imem_req},    32'd0);

        // 2: three advances with zero-wait memory
        for (int i = 1; i <= 3; i++) begin
            ic_count = 1'b1;
            step();
            ic_count = 1'b0;
            chk("t2_req",   {31'd0, imem_req},    32'd1);
            chk("t2_addr",  imem_addr,            32'(4 * i));
            chk("t2_vlow",  {31'd0, instr_valid}, 32'd0);
            imem_ack = 1'b1; imem_rdata = 32'hA000_0000 + 32'(i);
            step();
            imem_ack = 1'b0;
            chk("t2_valid", {31'd0, instr_valid}, 32'd1);
            chk("t2_instr", instr_out,            32'hA000_0000 + 32'(i));
        end

        // 3: redirect while a request is outstanding; stale word must be dropped
        ic_count = 1'b1;
        step();
        ic_count = 1'b0;
        chk("t3_addr_old", imem_addr, 32'h10);
        step();
        ic_wr_en = 1'b1; ic_target = 32'h100;
        step();
        ic_wr_en = 1'b0;
        chk("t3_pc_redir", pc_out,               32'h100);
        chk("t3_valid0",   {31'd0, instr_valid}, 32'd0);
        step();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        chk("t3_gap_req",   {31'd0, imem_req},    32'd0);
        chk("t3_gap_valid", {31'd0, instr_valid}, 32'd0);
        step();
        chk("t3_rereq",  {31'd0, imem_req}, 32'd1);
        chk("t3_readdr", imem_addr,         32'h100);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 1'b0;
        chk("t3_instr", instr_out,            32'h1234_5678);
        chk("t3_valid", {31'd0, instr_valid}, 32'd1);

        // 4: redirect and advance together from pc=0x8; redirect wins
        ic_wr_en = 1'b1; ic_target = 32'h8;
        step();
        ic_wr_en = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h0000_0808;
        step();
        imem_ack = 1'b0;
        chk("t4_pc8", pc_out, 32'h8);
        ic_count = 1'b1; ic_wr_en = 1'b1; ic_target = 32'h40;
        step();
        ic_count = 1'b0; ic_wr_en = 1'b0;
        chk("t4_pc",   pc_out,    32'h40);
        chk("t4_addr", imem_addr, 32'h40);
        imem_ack = 1'b1; imem_rdata = 32'h0000_4040;
        step();
        imem_ack = 1'b0;
        chk("t4_pc_hold", pc_out, 32'h40);

        // 5: PC wrap, then misaligned redirect locks the unit in error
        ic_wr_en = 1'b1; ic_target = 32'hFFFF_FFFC;
        step();
        ic_wr_en = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h0000_FFFC;
        step();
        imem_ack = 1'b0;
        ic_count = 1'b1;
        step();
        ic_count = 1'b0;
        chk("t5_wrap", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0001;
        step();
        imem_ack = 1'b0;
        ic_wr_en = 1'b1; ic_target = 32'h102;
        step();
        ic_wr_en = 1'b0;
        chk("t5_err",   {31'd0, fetch_err},   32'd1);
        chk("t5_req",   {31'd0, imem_req},    32'd0);
        chk("t5_valid", {31'd0, instr_valid}, 32'd0);
        chk("t5_instr", instr_out,            C_NOP);
        ic_count = 1'b1; imem_ack = 1'b1;
        step(); step();
        ic_count = 1'b0; imem_ack = 1'b0;
        chk("t5_stuck_err", {31'd0, fetch_err}, 32'd1);
        chk("t5_stuck_req", {31'd0, imem_req},  32'd0);

        // async reset while in error clears it immediately
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_err_async", {31'd0, fetch_err}, 32'd0);

        // 6: timeout with no ack ever
        step();
        rst_n = 1'b1;
        step();
        chk("t6_req_c1", {31'd0, imem_req}, 32'd1);
        for (int i = 0; i < C_TIMEOUT - 1; i++) step();
        chk("t6_err_pre", {31'd0, fetch_err}, 32'd0);
        chk("t6_req_pre", {31'd0, imem_req},  32'd1);
        step();
        chk("t6_err", {31'd0, fetch_err}, 32'd1);
        chk("t6_req", {31'd0, imem_req},  32'd0);

        // reset pulse in the middle of a request drops imem_req without a clock edge
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("t6_req_again", {31'd0, imem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_req_async", {31'd0, imem_req},  32'd0);
        chk("t6_rst_err0",      {31'd0, fetch_err}, 32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
